imem_loader: RTL and testbench

- Writer side of the processor's instruction memory. Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Writes the words into an internal word-addressed instruction RAM. The processor's fetch path reads this RAM through a combinational port, the same as the existing instruction memory.
- Holds the processor in reset (cpu_reset) until a load completes.

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the word-addressed instruction RAM; holds the CPU in reset until a load completes.
// Optional XOR checksum of written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded,
    output logic          cpu_reset,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic [31:0]   checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   asm_q, asm_d;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          wr_en;
    logic          last_slot;
    logic          load_start;
    logic [31:0]   wr_word;

    assign in_ready     = (state_q == LOAD);
    assign done         = (state_q == DONE);
    assign cpu_reset    = (state_q != DONE);
    assign error        = err_q;
    assign words_loaded = cnt_q;

    assign accept     = (state_q == LOAD) && in_valid;
    assign wr_en      = accept && ((bidx_q == 2'd3) || in_last);
    assign last_slot  = (waddr_q == AW'(DEPTH - 1));
    assign load_start = start && (state_q != LOAD);

    // Byte 0 clears the lower lanes, so a short final word is zero-filled.
    always_comb begin
        wr_word = asm_q;
        case (bidx_q)
            2'd0: wr_word = {in_data, 24'h0};
            2'd1: wr_word = {asm_q[31:24], in_data, 16'h0};
            2'd2: wr_word = {asm_q[31:16], in_data, 8'h0};
            2'd3: wr_word = {asm_q[31:8], in_data};
            default: wr_word = asm_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        asm_d   = asm_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    bidx_d  = 2'd0;
                    waddr_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    asm_d  = wr_word;
                    bidx_d = bidx_q + 2'd1;
                    if (wr_en) begin
                        bidx_d  = 2'd0;
                        waddr_d = waddr_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        if (in_last) begin
                            err_d   = (bidx_q != 2'd3);
                            state_d = DONE;
                        end else if (last_slot) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bidx_q  <= 2'd0;
            waddr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            asm_q   <= asm_d;
        end
    end

    // RAM is not reset: words from an aborted load survive.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr_q] <= wr_word;
        end
    end

    assign rd_data = mem[rd_addr];

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (load_start) begin
            chk_d = '0;
        end else if (wr_en) begin
            chk_d = chk_q ^ wr_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign checksum = chk_q;
`else
    logic unused_start;
    assign unused_start = load_start;
    assign checksum     = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a queue-based model of the load protocol.
// Literal checks pin the documented load scenarios.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;
    logic        cpu_reset;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] checksum;

    int n_chk = 0;
    int n_fail = 0;
    bit rnd_addr = 0;

    imem_loader #(.DEPTH(64), .AW(6)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .done(done),
        .error(error),
        .words_loaded(words_loaded),
        .cpu_reset(cpu_reset),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .checksum(checksum)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // model: 0 idle, 1 loading, 2 done
    int          m_state = 0;
    logic [7:0]  m_q[$];
    int          m_words = 0;
    bit          m_err = 0;
    logic [31:0] m_chk = 0;
    logic [31:0] m_ram[64];
    bit          m_known[64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic [31:0] w;
        if (reset) begin
            m_state = 0;
            m_q.delete();
            m_words = 0;
            m_err = 0;
            m_chk = 0;
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1;
                m_q.delete();
                m_words = 0;
                m_err = 0;
                m_chk = 0;
            end
        end else if (in_valid) begin
            m_q.push_back(in_data);
            if (in_last || m_q.size() == 4) begin
                w = 0;
                for (int i = 0; i < m_q.size(); i++)
                    w[31-8*i -: 8] = m_q[i];
                m_ram[m_words] = w;
                m_known[m_words] = 1;
                m_words++;
                m_chk ^= w;
                if (in_last) begin
                    m_err = (m_q.size() < 4);
                    m_state = 2;
                end else if (m_words == 64) begin
                    m_state = 2;
                end
                m_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_state == 1});
        chk("done", {31'b0, done}, {31'b0, m_state == 2});
        chk("cpu_reset", {31'b0, cpu_reset}, {31'b0, m_state != 2});
        chk("words_loaded", {25'b0, words_loaded}, m_words);
        chk("error", {31'b0, error}, {31'b0, m_err});
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("checksum", checksum, m_chk);
`else
        chk("checksum", checksum, 32'h0);
`endif
        if (m_known[rd_addr])
            chk("rd_data", rd_data, m_ram[rd_addr]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_addr) rd_addr = 6'($urandom_range(0, 63));
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1;
        in_data = b;
        in_last = last;
        tick();
        in_valid = 0;
        in_last = 0;
        in_data = 8'($urandom);
    endtask

    task automatic readchk(input string nm, input logic [5:0] a,
                           input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(nm, rd_data, exp);
    endtask

    task automatic send_prog(input int gap);
        logic [7:0] p[8];
        p = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        for (int i = 0; i < 8; i++) begin
            send(p[i], i == 7);
            if (i == 1) repeat (gap) tick();
        end
    endtask

    task automatic check_prog(input string tag);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 32'd0);
        chk({tag, "_wl"}, {25'b0, words_loaded}, 32'd2);
        chk({tag, "_err"}, {31'b0, error}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tag, "_chk"}, checksum, 32'hAC030001);
`endif
        readchk({tag, "_ram0"}, 6'd0, 32'h8C010004);
        readchk({tag, "_ram1"}, 6'd1, 32'h20020005);
    endtask

    initial begin
        int len;
        bit last;
        reset = 0;
        start = 0;
        in_valid = 0;
        in_data = 0;
        in_last = 0;
        rd_addr = 0;
        #2 reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("rst_wl", {25'b0, words_loaded}, 32'd0);
        reset = 0;
        tick();

        pulse_start();
        send_prog(0);
        check_prog("prog");

        pulse_start();
        send_prog(3);
        check_prog("gap");

        pulse_start();
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 1);
        chk("part_wl", {25'b0, words_loaded}, 32'd1);
        chk("part_err", {31'b0, error}, 32'd1);
        chk("part_done", {31'b0, done}, 32'd1);
        readchk("part_ram0", 6'd0, 32'hAABBCC00);

        pulse_start();
        for (int i = 0; i < 256; i++) send(8'(i), 0);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        send(8'h99, 0);
        send(8'h98, 1);
        chk("full_wl", {25'b0, words_loaded}, 32'd64);
        chk("full_done", {31'b0, done}, 32'd1);
        chk("full_err", {31'b0, error}, 32'd0);
        readchk("full_ram63", 6'd63, 32'hFCFDFEFF);
        readchk("full_ram0", 6'd0, 32'h00010203);

        pulse_start();
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        reset = 1;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_wl", {25'b0, words_loaded}, 32'd0);
        readchk("abort_ram0", 6'd0, 32'h11223344);
        tick();
        reset = 0;
        tick();
        pulse_start();
        send(8'hDE, 0);
        send(8'hAD, 0);
        send(8'hBE, 0);
        send(8'hEF, 1);
        chk("reload_wl", {25'b0, words_loaded}, 32'd1);
        chk("reload_done", {31'b0, done}, 32'd1);
        readchk("reload_ram0", 6'd0, 32'hDEADBEEF);

        pulse_start();
        send(8'h01, 0);
        send(8'h02, 0);
        pulse_start();
        send(8'h03, 0);
        send(8'h04, 1);
        chk("restart_ign_wl", {25'b0, words_loaded}, 32'd1);
        chk("restart_ign_done", {31'b0, done}, 32'd1);
        readchk("restart_ign_ram0", 6'd0, 32'h01020304);
        pulse_start();
        chk("redo_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("redo_wl", {25'b0, words_loaded}, 32'd0);

        rnd_addr = 1;
        for (int ld = 0; ld < 40; ld++) begin
            pulse_start();
            len = (ld % 10 == 3) ? $urandom_range(250, 270)
                                 : $urandom_range(1, 80);
            for (int i = 0; i < len; i++) begin
                last = (i == len - 1) && ($urandom_range(0, 3) != 0);
                send(8'($urandom), last);
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 15) == 0) pulse_start();
                if ($urandom_range(0, 299) == 0) begin
                    reset = 1;
                    tick();
                    reset = 0;
                end
            end
            repeat ($urandom_range(1, 4)) tick();
        end
        rnd_addr = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
